// File: rtl/d8m_tx_pkg.sv
// d8m_tx_pkg: shared constants for the synthetic D8M camera source.
// FSM state codes, pattern select codes and the checkerboard cell size.
package d8m_tx_pkg;

    // Raster FSM state codes (plain constants so older tools and checkers can bind to them).
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FSTART = 3'd1;
    localparam state_t ST_LINE   = 3'd2;
    localparam state_t ST_HBLANK = 3'd3;
    localparam state_t ST_VBLANK = 3'd4;

    // Test pattern select codes.
    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FLAT  = 2'd3
    } pat_sel_e;

    // Checkerboard cell edge is 2**CHECK_SHIFT pixels.
    localparam int CHECK_SHIFT = 3;

    // Width of the pixel coordinates handed to the pattern generator.
    localparam int COORD_W = 16;

endpackage

// File: rtl/d8m_pattern_tx_if.sv
// d8m_pattern_tx_if: parallel camera pixel bus (FVAL / LVAL / data).
// Stream semantics: there is no backpressure. pix_d is meaningful only in
// cycles where pix_fval and pix_lval are both high; pix_d is driven to 0
// otherwise. The source (master) owns every signal, the sink only samples.
interface d8m_pattern_tx_if #(
    parameter int PIX_W = 10
);
    logic [PIX_W-1:0] pix_d;
    logic             pix_fval;
    logic             pix_lval;

    modport master (output pix_d, output pix_fval, output pix_lval);
    modport slave  (input  pix_d, input  pix_fval, input  pix_lval);
endinterface

// File: rtl/d8m_tx_pattern.sv
// d8m_tx_pattern: combinational pixel value from coordinates and pattern code.
// Optional macro D8M_PATTERN_TX_SCROLL_EN: ramps are offset by the frame
// counter so they move one step per frame.
module d8m_tx_pattern
    import d8m_tx_pkg::*;
#(
    parameter int PIX_W = 10
) (
    input  logic [1:0]         sel_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [15:0]        frame_count_i,
    output logic [PIX_W-1:0]   pix_o
);

    logic [PIX_W-1:0] scroll;
    logic [PIX_W-1:0] x_pix;
    logic [PIX_W-1:0] y_pix;
    logic             unused_bits;

`ifdef D8M_PATTERN_TX_SCROLL_EN
    assign scroll = PIX_W'(frame_count_i);
`else
    assign scroll = '0;
`endif

    // Ramps wrap naturally at 2**PIX_W through the truncating add.
    assign x_pix = PIX_W'(x_i) + scroll;
    assign y_pix = PIX_W'(y_i) + scroll;

    // Only some coordinate / counter bits feed the pattern in a given build.
    assign unused_bits = ^{frame_count_i, x_i, y_i};

    // Select the pixel value for the latched pattern.
    always_comb begin
        pix_o = '0;
        case (sel_i)
            PAT_HRAMP: pix_o = x_pix;
            PAT_VRAMP: pix_o = y_pix;
            PAT_CHECK: pix_o = (x_i[CHECK_SHIFT] ^ y_i[CHECK_SHIFT]) ? '1 : '0;
            PAT_FLAT:  pix_o = '1;
            default:   pix_o = '0;
        endcase
    end

endmodule

// File: rtl/d8m_pattern_tx.sv
// d8m_pattern_tx: synthetic D8M parallel-camera source. Raster FSM and
// counters live here; pixel values come from d8m_tx_pattern. All outputs
// are registered from the current state, so they trail the state by one
// cycle. Optional macro D8M_PATTERN_TX_SCROLL_EN enables scrolling ramps.
module d8m_pattern_tx
    import d8m_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int PIX_W    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    d8m_pattern_tx_if.master pix_if,
    output logic [15:0]      frame_count,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int LINE_CYC = H_ACTIVE + H_BLANK;
    localparam int VB_CYC   = V_BLANK * LINE_CYC;
    localparam int HMAX     = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int CNT_MAX  = (VB_CYC > HMAX) ? VB_CYC : HMAX;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        fc_q;
    logic               fval_q, lval_q, busy_q;
    logic [PIX_W-1:0]   pix_q;
    logic [PIX_W-1:0]   pat_pix;

    // One shared cycle counter: FSTART/HBLANK length, x position in LINE,
    // and the whole vertical blank interval in VBLANK.
    logic cnt_hb_last, cnt_ha_last, cnt_vb_last, y_last;
    assign cnt_hb_last = (cnt_q == CNT_W'(H_BLANK - 1));
    assign cnt_ha_last = (cnt_q == CNT_W'(H_ACTIVE - 1));
    assign cnt_vb_last = (cnt_q == CNT_W'(VB_CYC - 1));
    assign y_last      = (y_q == Y_W'(V_ACTIVE - 1));

    d8m_tx_pattern #(
        .PIX_W(PIX_W)
    ) u_pattern (
        .sel_i         (sel_q),
        .x_i           (COORD_W'(cnt_q)),
        .y_i           (COORD_W'(y_q)),
        .frame_count_i (fc_q),
        .pix_o         (pat_pix)
    );

    // Raster sequencing; enable and pattern_sel only matter at frame boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_FSTART;
                    sel_d   = pattern_sel;
                end
            end
            ST_FSTART: begin
                if (cnt_hb_last) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LINE: begin
                if (cnt_ha_last) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_hb_last) begin
                    cnt_d = '0;
                    if (!y_last) begin
                        state_d = ST_LINE;
                        y_d     = y_q + 1'b1;
                    end else begin
                        state_d = ST_VBLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (cnt_vb_last) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = ST_FSTART;
                        sel_d   = pattern_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counters and latched pattern select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
        end
    end

    // Registered bus outputs; frame counter bumps on the first VBLANK cycle,
    // which lines it up with the falling edge of fval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            busy_q <= 1'b0;
            pix_q  <= '0;
            fc_q   <= '0;
        end else begin
            fval_q <= (state_q == ST_FSTART) || (state_q == ST_LINE) || (state_q == ST_HBLANK);
            lval_q <= (state_q == ST_LINE);
            busy_q <= (state_q != ST_IDLE);
            pix_q  <= (state_q == ST_LINE) ? pat_pix : '0;
            if ((state_q == ST_VBLANK) && (cnt_q == '0)) begin
                fc_q <= fc_q + 16'd1;
            end
        end
    end

    assign pix_if.pix_d    = pix_q;
    assign pix_if.pix_fval = fval_q;
    assign pix_if.pix_lval = lval_q;
    assign frame_count     = fc_q;
    assign busy            = busy_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_d8m_pattern_tx.sv
// tb_d8m_pattern_tx: self-checking bench for d8m_pattern_tx. A small raster
// instance (8x4, blanks 4/2) is checked cycle by cycle against a frame-level
// model; a 16x16 instance checks the checkerboard layout from a vector table.
module tb_d8m_pattern_tx;

    localparam int SHA = 8;
    localparam int SHB = 4;
    localparam int SVA = 4;
    localparam int SVB = 2;
    localparam int P   = SHB + (SVA + SVB) * (SHA + SHB);   // 76
    localparam int SW  = 29;

`ifdef D8M_PATTERN_TX_SCROLL_EN
    localparam int SCROLL = 1;
`else
    localparam int SCROLL = 0;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_enable, b_enable;
    logic [1:0]  s_sel, b_sel;
    logic [15:0] s_fc, b_fc;
    logic        s_busy, b_busy;
    logic [2:0]  s_dbg, b_dbg;

    always #5 clk = ~clk;

    d8m_pattern_tx_if #(.PIX_W(10)) s_if ();
    d8m_pattern_tx_if #(.PIX_W(10)) b_if ();

    d8m_pattern_tx #(
        .H_ACTIVE(SHA), .H_BLANK(SHB), .V_ACTIVE(SVA), .V_BLANK(SVB), .PIX_W(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(s_enable), .pattern_sel(s_sel),
        .pix_if(s_if), .frame_count(s_fc), .busy(s_busy), .dbg_state(s_dbg)
    );

    d8m_pattern_tx #(
        .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(16), .V_BLANK(2), .PIX_W(10)
    ) dut_big (
        .clk(clk), .reset_n(reset_n), .enable(b_enable), .pattern_sel(b_sel),
        .pix_if(b_if), .frame_count(b_fc), .busy(b_busy), .dbg_state(b_dbg)
    );

    // ---------------- scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [SW-1:0]   exp_q[$];
    logic [15:0]     m_fc;
    int              frame_sel[8];
    int              rise_c[$];
    int              lval_first;

    typedef struct {
        int         x;
        int         y;
        logic [9:0] exp_d;
    } chk_vec_t;
    chk_vec_t   vecs[10];
    logic [9:0] cap[16][16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [9:0] pix_model(input int sel, input int x, input int y, input int fc);
        int sc;
        sc = SCROLL * fc;
        case (sel)
            0:       return 10'((x + sc) % 1024);
            1:       return 10'((y + sc) % 1024);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
            default: return 10'h3FF;
        endcase
    endfunction

    function automatic logic [SW-1:0] pack(input logic busy, input logic fval, input logic lval,
                                           input logic [9:0] d, input logic [15:0] fc);
        return {busy, fval, lval, d, fc};
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 10'h0, m_fc));
    endtask

    // One whole frame as seen on the bus: lead-in, lines with gaps, vertical blank.
    task automatic push_frame(input int sel);
        logic [15:0] fc0;
        fc0 = m_fc;
        repeat (SHB) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 10'h0, fc0));
        for (int y = 0; y < SVA; y++) begin
            for (int x = 0; x < SHA; x++)
                exp_q.push_back(pack(1'b1, 1'b1, 1'b1, pix_model(sel, x, y, int'(fc0)), fc0));
            repeat (SHB) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 10'h0, fc0));
        end
        m_fc = m_fc + 16'd1;
        repeat (SVB * (SHA + SHB)) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 10'h0, m_fc));
    endtask

    // ---------------- driver + stream checker ----------------
    // Frame f is requested at the edge after negedge f*P. Between boundaries
    // inputs are either scrambled (chaos), or sel moves to the next frame's
    // value halfway through and enable drops at drop_cyc.
    task automatic run_seq(input int nf, input int drop_cyc, input bit chaos, input string tag);
        int            total;
        logic [SW-1:0] got, e;
        logic          prev_fval, prev_lval;
        exp_q.delete();
        rise_c.delete();
        lval_first = -1;
        prev_fval  = 1'b0;
        prev_lval  = 1'b0;
        push_idle(2);
        for (int f = 0; f < nf; f++) push_frame(frame_sel[f]);
        push_idle(3);
        total = exp_q.size();
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            got = pack(s_busy, s_if.pix_fval, s_if.pix_lval, s_if.pix_d, s_fc);
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s stream c=%0d: got busy=%0b fval=%0b lval=%0b d=0x%0h fc=%0d, expected busy=%0b fval=%0b lval=%0b d=0x%0h fc=%0d",
                         tag, c, got[28], got[27], got[26], got[25:16], got[15:0],
                         e[28], e[27], e[26], e[25:16], e[15:0]);
            end
            if (s_if.pix_fval && !prev_fval) rise_c.push_back(c);
            if (s_if.pix_lval && !prev_lval && lval_first < 0) lval_first = c;
            prev_fval = s_if.pix_fval;
            prev_lval = s_if.pix_lval;
            if (c % P == 0) begin
                if (c / P < nf) begin
                    s_enable = 1'b1;
                    s_sel    = 2'(frame_sel[c / P]);
                end else begin
                    s_enable = 1'b0;
                    s_sel    = 2'($urandom_range(0, 3));
                end
            end else if (c >= nf * P) begin
                s_enable = 1'b0;
                s_sel    = 2'($urandom_range(0, 3));
            end else if (chaos) begin
                s_enable = 1'($urandom_range(0, 1));
                s_sel    = 2'($urandom_range(0, 3));
            end else begin
                s_enable = (drop_cyc >= 0 && c >= drop_cyc) ? 1'b0 : 1'b1;
                s_sel    = 2'((c % P < P / 2) ? frame_sel[c / P] : frame_sel[c / P + 1]);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int x, y, lines, npix;
        logic prev_l;
        logic seen_line;

        vecs[0] = '{0,  0,  10'h000};
        vecs[1] = '{7,  0,  10'h000};
        vecs[2] = '{8,  0,  10'h3FF};
        vecs[3] = '{15, 0,  10'h3FF};
        vecs[4] = '{0,  8,  10'h3FF};
        vecs[5] = '{7,  8,  10'h3FF};
        vecs[6] = '{8,  8,  10'h000};
        vecs[7] = '{15, 15, 10'h000};
        vecs[8] = '{3,  12, 10'h3FF};
        vecs[9] = '{12, 3,  10'h3FF};

        reset_n  = 1'b0;
        s_enable = 1'b0;
        b_enable = 1'b0;
        s_sel    = 2'd0;
        b_sel    = 2'd0;
        m_fc     = 16'd0;
        for (int i = 0; i < 8; i++) frame_sel[i] = 0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("reset_small", {s_busy, s_if.pix_fval, s_if.pix_lval, s_if.pix_d, s_fc, s_dbg}, 32'h0);
        check("reset_big",   {b_busy, b_if.pix_fval, b_if.pix_lval, b_if.pix_d, b_fc, b_dbg}, 32'h0);
        reset_n = 1'b1;

        // Idle with enable low for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {s_busy, s_if.pix_fval, s_if.pix_lval, s_if.pix_d, s_fc}, 32'h0);
        end

        // Continuous horizontal ramp, two frames.
        frame_sel[0] = 0; frame_sel[1] = 0; frame_sel[2] = 0;
        run_seq(2, -1, 1'b0, "hramp");
        check("fval_rise_count", rise_c.size(), 2);
        check("fval_to_lval", lval_first - (rise_c.size() > 0 ? rise_c[0] : 0), SHB);
        check("frame_period", (rise_c.size() > 1) ? rise_c[1] - rise_c[0] : 0, P);
        check("fc_after_hramp", s_fc, 2);

        // enable dropped in the middle of line 2: the frame still completes.
        frame_sel[0] = 1; frame_sel[1] = 3;
        run_seq(1, 1 + SHB + 2 * (SHA + SHB) + 3, 1'b0, "drop_mid");
        check("drop_busy_low", s_busy, 0);
        check("drop_state_idle", s_dbg, 0);
        check("drop_fc", s_fc, 3);

        // sel changed 0 -> 3 mid-frame: frame 0 stays ramp, frame 1 flat.
        frame_sel[0] = 0; frame_sel[1] = 3; frame_sel[2] = 2;
        run_seq(2, -1, 1'b0, "sel_change");

        // Asynchronous reset during an active line.
        s_sel    = 2'd0;
        s_enable = 1'b1;
        seen_line = 1'b0;
        for (int i = 0; i < 40 && !seen_line; i++) begin
            @(negedge clk);
            if (s_if.pix_lval) seen_line = 1'b1;
        end
        check("reached_line", seen_line, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {s_busy, s_if.pix_fval, s_if.pix_lval, s_if.pix_d, s_fc}, 32'h0);
        s_enable = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_fc = 16'd0;
        frame_sel[0] = 0; frame_sel[1] = 0; frame_sel[2] = 1;
        run_seq(2, -1, 1'b0, "after_reset");
        check("fc_after_restart", s_fc, 2);

        // Checkerboard on a 16x16 raster, compared against the vector table.
        @(negedge clk);
        b_enable = 1'b1;
        b_sel    = 2'd2;
        @(negedge clk);
        b_enable = 1'b0;
        b_sel    = 2'd0;
        x = 0; y = 0; lines = 0; npix = 0; prev_l = 1'b0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (b_if.pix_lval) begin
                if (x < 16 && y < 16) cap[y][x] = b_if.pix_d;
                x++;
                npix++;
            end else if (prev_l) begin
                y++;
                x = 0;
                lines++;
            end
            prev_l = b_if.pix_lval;
        end
        check("check_lines", lines, 16);
        check("check_pixels", npix, 256);
        for (int i = 0; i < 10; i++)
            check($sformatf("checker(%0d,%0d)", vecs[i].x, vecs[i].y),
                  cap[vecs[i].y][vecs[i].x], vecs[i].exp_d);
        check("big_busy_done", b_busy, 0);
        check("big_fc", b_fc, 1);

        // Randomized runs with scrambled inputs between frame boundaries.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) frame_sel[i] = $urandom_range(0, 3);
            run_seq($urandom_range(1, 3), -1, 1'b1, $sformatf("rand%0d", r));
        end
        check("fc_final", s_fc, m_fc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d8m_pattern_tx.md
# d8m_pattern_tx

Synthetic D8M parallel-camera source: generates the FVAL/LVAL/10-bit pixel stream that the D8M bridge drives into the camera capture path, with selectable test patterns and configurable raster geometry. Used in simulation and on-board bring-up in place of the MIPI bridge, feeding the camera receiver so the capture → frame buffer → VGA chain can be verified without a sensor.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (LVAL high cycles)
- H_BLANK, 160, idle cycles between lines; also the FVAL-to-first-LVAL gap
- V_ACTIVE, 480, lines per frame
- V_BLANK, 45, blank lines (FVAL low) after each frame
- PIX_W, 10, pixel width

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- pattern_sel  in  2  0 horizontal ramp, 1 vertical ramp, 2 8×8 checkerboard, 3 flat max
- pix_d  out  PIX_W  pixel data
- pix_fval  out  1  frame valid
- pix_lval  out  1  line valid
- frame_count  out  16  completed-frame counter
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, FSTART, LINE, HBLANK, VBLANK.
- IDLE: fval=lval=0, d=0. enable=1 → FSTART; pattern_sel latched on this transition.
- FSTART: fval=1, lval=0 for H_BLANK cycles → LINE (x=0, y=0).
- LINE: fval=1, lval=1, H_ACTIVE cycles, x increments 0..H_ACTIVE-1 → HBLANK.
- HBLANK: fval=1, lval=0, H_BLANK cycles; then y<V_ACTIVE-1 → LINE with y+1, x=0; else → VBLANK.
- VBLANK: fval=0 for V_BLANK×(H_ACTIVE+H_BLANK) cycles; on entry frame_count increments (wraps 0xFFFF→0). At end: enable=1 → FSTART (re-latch pattern_sel), else → IDLE.
- enable deassert mid-frame: current frame completes including VBLANK; no truncated frames ever.
- pattern_sel changes mid-frame: ignored until next FSTART.
- Pixel values (LINE only; d=0 whenever lval=0): sel0 = x mod 2^PIX_W; sel1 = y mod 2^PIX_W; sel2 = (x[3]^y[3]) ? all-ones : 0; sel3 = all-ones.
- Counters sized $clog2 of their maximum; blank counter covers V_BLANK×(H_ACTIVE+H_BLANK).

## Timing
- All outputs registered; reset values: pix_d=0, pix_fval=0, pix_lval=0, frame_count=0, busy=0, state IDLE.
- enable sampled high in IDLE at edge N → fval=1 and busy=1 after edge N+1 (1-cycle latency).
- First lval rises exactly H_BLANK cycles after fval rises; pix_d valid in the same cycle as lval.
- fval falls the cycle after the last HBLANK cycle of the last line.
- Frame period (continuous enable): H_BLANK + (V_ACTIVE+V_BLANK)×(H_ACTIVE+H_BLANK) cycles.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous); after release restart from IDLE.

## Configuration
- D8M_PATTERN_TX_SCROLL_EN defined: patterns 0 and 1 add frame_count (truncated to PIX_W) to x resp. y, mod 2^PIX_W, so ramps move one step per frame. Undefined: static ramps as above. Other patterns, timing and frame_count unaffected either way.

## Structure
- Package d8m_tx_pkg: state enum, pattern_sel codes (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_FLAT), CHECK_SHIFT=3.
- Sub-module d8m_tx_pattern: pixel value from x, y, latched sel, frame_count; raster FSM and counters stay in top.

## Test plan
Params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_BLANK=2, PIX_W=10 unless noted.
- Reset, enable=0 for 50 cycles → all outputs 0, busy=0.
- enable=1 held, sel=0 → fval high 4 cycles before first lval; 4 lines of 8 pixels 0..7; frame period 76 cycles; frame_count 0→1 at fval fall.
- sel=2, H_ACTIVE=16, V_ACTIVE=16 → line 0 pixels 0–7 = 0, 8–15 = 0x3FF; line 8 inverted.
- enable dropped mid line 2 → frame completes (4 lines, VBLANK 24 cycles), then IDLE, busy=0, frame_count=1.
- sel changed 0→3 mid-frame → current frame stays ramp; next frame all 0x3FF.
- reset_n pulsed low during LINE → fval/lval/d=0 same cycle; restart yields full frame from FSTART; with SCROLL_EN, frame 2 line 0 starts at pixel value 1.
